// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master datapath: mode codes, receive FSM
// states, sck divider sizing and width clamping.
package spi_pkg;

  localparam logic [1:0] MODE_RD     = 2'b00;
  localparam logic [1:0] MODE_WR     = 2'b01;
  localparam logic [1:0] MODE_CMD_RD = 2'b10;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'b00,
    RX_SKIP    = 2'b01,
    RX_SHIFT   = 2'b10,
    RX_WAIT_CS = 2'b11
  } rx_state_e;

  // clk cycles between sck edges; never fewer than 4 so edge detection keeps up
  function automatic int unsigned sck_div(input int unsigned sys_clk, input int unsigned rate);
    int unsigned n;
    n = sys_clk / rate;
    return (n < 4) ? 4 : n;
  endfunction

  function automatic logic [5:0] clamp_width(input logic [5:0] w);
    return (w > 6'd32) ? 6'd32 : w;
  endfunction

endpackage

// File: rtl/spi_edge_det.sv
// Registers cs/sck once and flags cs edges and the configured sck sample edge.
module spi_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic cs,
  input  logic sck,
  input  logic cpol,
  input  logic cpha,
  output logic cs_fall,
  output logic cs_rise,
  output logic sample_edge
);

  logic cs_q, cs_d;
  logic sck_q, sck_d;
  logic sck_rise, sck_fall;

  always_comb begin
    cs_d  = cs;
    sck_d = sck;
  end

  // sck history restarts at the idle level so reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q  <= 1'b1;
      sck_q <= cpol;
    end else begin
      cs_q  <= cs_d;
      sck_q <= sck_d;
    end
  end

  assign cs_fall     = cs_q & ~cs;
  assign cs_rise     = ~cs_q & cs;
  assign sck_rise    = ~sck_q & sck;
  assign sck_fall    = sck_q & ~sck;
  assign sample_edge = (cpol == cpha) ? sck_rise : sck_fall;

endmodule

// File: rtl/spi_rx.sv
// SPI master receive path: packs MISO frames into right-justified 32-bit
// words and hands them out on an AXI4-Stream port with one holding register.
module spi_rx #(
  parameter int unsigned system_clk = 50_000000,
  parameter int unsigned spi_rate   = 5_000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        sck,
  input  logic        cpol,
  input  logic        cpha,
  input  logic [1:0]  w_r_mode,
  input  logic [5:0]  wr_width,
  input  logic [5:0]  rd_width,
  input  logic        miso,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        rx_busy,
  output logic        overflow,
  output logic        frame_err,
  output logic [15:0] rd_data_num
);
  import spi_pkg::*;

  if (spi_rate == 0 || spi_rate > system_clk) begin : g_bad_rate
    $error("spi_rate must be nonzero and no greater than system_clk");
  end

  logic cs_fall, cs_rise, sample_edge;

  spi_edge_det u_edge_det (
    .clk         (clk),
    .rst         (rst),
    .cs          (cs),
    .sck         (sck),
    .cpol        (cpol),
    .cpha        (cpha),
    .cs_fall     (cs_fall),
    .cs_rise     (cs_rise),
    .sample_edge (sample_edge)
  );

  rx_state_e   state_q, state_d, after_skip;
  logic [5:0]  cnt_q, cnt_d, skip_q, skip_d, rbits_q, rbits_d;
  logic [31:0] shreg_q, shreg_d, tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d, busy_q, busy_d;
  logic        ovf_q, ovf_d, ferr_q, ferr_d;
  logic [15:0] num_q, num_d;
  logic [5:0]  skip_w, rbits_w, cnt_inc;
  logic        rx_en, accept, load;

  assign rx_en   = (w_r_mode == MODE_RD) || (w_r_mode == MODE_CMD_RD);
  assign skip_w  = (w_r_mode == MODE_CMD_RD) ? clamp_width(wr_width) : 6'd0;
  assign rbits_w = clamp_width(rd_width);
  assign cnt_inc = cnt_q + 6'd1;
  assign accept  = tvalid_q & m_axis_tready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    rbits_d    = rbits_q;
    shreg_d    = shreg_q;
    busy_d     = busy_q;
    ovf_d      = ovf_q;
    ferr_d     = 1'b0;
    load       = 1'b0;
    after_skip = (rbits_q == 6'd0) ? RX_WAIT_CS : RX_SHIFT;

    // write-only/reserved modes park the FSM and silently abandon any frame
    if (!rx_en) begin
      state_d = RX_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        RX_IDLE: if (cs_fall) begin
          cnt_d   = 6'd0;
          shreg_d = 32'd0;
          busy_d  = 1'b1;
          skip_d  = skip_w;
          rbits_d = rbits_w;
          if (skip_w != 6'd0)       state_d = RX_SKIP;
          else if (rbits_w != 6'd0) state_d = RX_SHIFT;
          else                      state_d = RX_WAIT_CS;
        end
        RX_SKIP: if (cs_rise) begin
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = RX_IDLE;
        end else if (sample_edge) begin
          cnt_d = cnt_inc;
          if (cnt_inc == skip_q) begin
            cnt_d   = 6'd0;
            state_d = after_skip;
          end
        end
        RX_SHIFT: if (cs_rise) begin
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = RX_IDLE;
        end else if (sample_edge) begin
          shreg_d = {shreg_q[30:0], miso};
          cnt_d   = cnt_inc;
          if (cnt_inc == rbits_q) state_d = RX_WAIT_CS;
        end
        RX_WAIT_CS: if (cs_rise) begin
          busy_d  = 1'b0;
          state_d = RX_IDLE;
          if (rbits_q != 6'd0) begin
            if (!tvalid_q || m_axis_tready) load  = 1'b1;
            else                            ovf_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end

    // a fresh word may replace one being accepted in the same cycle
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    num_d    = num_q + {15'd0, accept};
    if (load) begin
      tvalid_d = 1'b1;
      tdata_d  = shreg_q;
    end else if (accept) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      cnt_q    <= 6'd0;
      skip_q   <= 6'd0;
      rbits_q  <= 6'd0;
      shreg_q  <= 32'd0;
      tdata_q  <= 32'd0;
      tvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      num_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      skip_q   <= skip_d;
      rbits_q  <= rbits_d;
      shreg_q  <= shreg_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
      ferr_q   <= ferr_d;
      num_q    <= num_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_busy       = busy_q;
  assign overflow      = ovf_q;
  assign frame_err     = ferr_q;
  assign rd_data_num   = num_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: emulates the cs/sck/miso bus and predicts delivered words,
// counters and flags from the frame rules.
module tb_spi_rx;
  import spi_pkg::*;

  localparam int H = int'(sck_div(50_000000, 5_000000) / 2);

  logic        clk = 1'b0;
  logic        rst, cs, sck, cpol, cpha, miso, m_axis_tready;
  logic [1:0]  w_r_mode;
  logic [5:0]  wr_width, rd_width;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, rx_busy, overflow, frame_err;
  logic [15:0] rd_data_num;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_rx #(.system_clk(50_000000), .spi_rate(5_000000)) dut (
    .clk(clk), .rst(rst), .cs(cs), .sck(sck), .cpol(cpol), .cpha(cpha),
    .w_r_mode(w_r_mode), .wr_width(wr_width), .rd_width(rd_width), .miso(miso),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .rx_busy(rx_busy), .overflow(overflow),
    .frame_err(frame_err), .rd_data_num(rd_data_num)
  );

  // observer: records every accepted word and counts flag cycles
  logic [31:0] got_data [0:255];
  int got_n = 0, vld_cycles = 0, err_pulses = 0, busy_cycles = 0;
  always @(negedge clk) begin
    if (m_axis_tvalid) vld_cycles++;
    if (m_axis_tvalid && m_axis_tready) begin
      got_data[8'(got_n)] = m_axis_tdata;
      got_n++;
    end
    if (frame_err) err_pulses++;
    if (rx_busy) busy_cycles++;
  end

  // reference model state
  logic        exp_pending, exp_overflow, exp_push, exp_err;
  logic [31:0] exp_pending_data, exp_word;
  logic [15:0] exp_num;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    exp_pending = 1'b0; exp_overflow = 1'b0; exp_num = 16'd0;
    exp_push = 1'b0; exp_err = 1'b0; exp_word = 32'd0; exp_pending_data = 32'd0;
  endtask

  task automatic model_drain();
    if (exp_pending && m_axis_tready) begin
      exp_pending = 1'b0;
      exp_num = exp_num + 16'd1;
    end
  endtask

  // outcome of one frame that saw 'edges' sample edges before cs rose
  task automatic model_frame(input logic [1:0] mode, input int wr, input int rd,
                             input int edges, input logic [31:0] data);
    int skip, rb;
    exp_push = 1'b0;
    exp_err  = 1'b0;
    if (mode == MODE_RD || mode == MODE_CMD_RD) begin
      skip = (mode == MODE_CMD_RD) ? ((wr > 32) ? 32 : wr) : 0;
      rb   = (rd > 32) ? 32 : rd;
      exp_word = (rb == 32) ? data : (data & ((32'h1 << rb) - 32'h1));
      if (edges < skip + rb) exp_err = 1'b1;
      else if (rb > 0) begin
        if (exp_pending) exp_overflow = 1'b1;
        else begin
          exp_pending = 1'b1;
          exp_pending_data = exp_word;
          exp_push = 1'b1;
        end
      end
    end
    model_drain();
  endtask

  task automatic spi_start();
    cs = 1'b0;
    tick(H);
  endtask

  task automatic spi_bit(input logic b);
    if (!cpha) begin
      miso = b; tick(H); sck = ~sck; tick(H); sck = ~sck;
    end else begin
      sck = ~sck; miso = b; tick(H); sck = ~sck; tick(H);
    end
  endtask

  task automatic spi_end();
    tick(H);
    cs = 1'b1;
    tick(H + 2);
  endtask

  task automatic run_frame(input logic [1:0] mode, input logic cp, input logic ch,
                           input int wr, input int rd, input logic [31:0] cmd,
                           input logic [31:0] data, input int edges, input int extra);
    int skip, rb;
    w_r_mode = mode; cpol = cp; cpha = ch;
    wr_width = 6'(wr); rd_width = 6'(rd);
    sck = cp;
    tick(2);
    skip = (mode == MODE_CMD_RD) ? ((wr > 32) ? 32 : wr) : 0;
    rb   = (rd > 32) ? 32 : rd;
    spi_start();
    for (int k = 0; k < edges + extra; k++) begin
      if (k < skip)           spi_bit(cmd[skip - 1 - k]);
      else if (k < skip + rb) spi_bit(data[rb - 1 - (k - skip)]);
      else                    spi_bit(1'($urandom));
    end
    spi_end();
    model_frame(mode, wr, rd, edges, data);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    model_reset();
    checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (rx_busy !== 1'b0 || overflow !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: busy=%b ovf=%b ferr=%b want 000", rx_busy, overflow, frame_err); end
    checks++; if (rd_data_num !== 16'd0) begin errors++; $display("FAIL reset_num: got %0d want 0", rd_data_num); end
  endtask

  task automatic test_read_basic();
    int n0, v0, b0;
    m_axis_tready = 1'b1;
    n0 = got_n; v0 = vld_cycles; b0 = busy_cycles;
    run_frame(MODE_RD, 1'b0, 1'b0, 0, 8, 32'd0, 32'hA5, 8, 0);
    checks++; if (got_n - n0 != 1 || got_data[8'(n0)] !== 32'h0000_00A5) begin
      errors++; $display("FAIL basic_word: count %0d data %h want 1 word 000000a5", got_n - n0, got_data[8'(n0)]); end
    checks++; if (vld_cycles - v0 != 1) begin errors++; $display("FAIL basic_tvalid_len: got %0d cycles want 1", vld_cycles - v0); end
    checks++; if (rd_data_num !== exp_num) begin errors++; $display("FAIL basic_num: got %0d want %0d", rd_data_num, exp_num); end
    checks++; if (busy_cycles == b0) begin errors++; $display("FAIL basic_busy: got 0 busy cycles want >0"); end
  endtask

  task automatic test_cmd_read();
    int n0;
    n0 = got_n;
    run_frame(MODE_CMD_RD, 1'b1, 1'b1, 8, 16, 32'hFF, 32'h1234, 24, 0);
    checks++; if (got_n - n0 != 1 || got_data[8'(n0)] !== 32'h0000_1234) begin
      errors++; $display("FAIL cmd_word: count %0d data %h want 1 word 00001234", got_n - n0, got_data[8'(n0)]); end
    checks++; if (rd_data_num !== exp_num) begin errors++; $display("FAIL cmd_num: got %0d want %0d", rd_data_num, exp_num); end
  endtask

  task automatic test_back_to_back();
    int n0;
    logic [15:0] num0;
    n0 = got_n; num0 = rd_data_num;
    m_axis_tready = 1'b0;
    run_frame(MODE_RD, 1'b0, 1'b1, 0, 32, 32'd0, 32'hDEADBEEF, 32, 0);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_first: tvalid=%b tdata=%h want 1 deadbeef", m_axis_tvalid, m_axis_tdata); end
    run_frame(MODE_RD, 1'b0, 1'b1, 0, 32, 32'd0, 32'h01234567, 32, 0);
    checks++; if (m_axis_tdata !== exp_pending_data || overflow !== exp_overflow) begin
      errors++; $display("FAIL b2b_hold: tdata=%h ovf=%b want %h %b", m_axis_tdata, overflow, exp_pending_data, exp_overflow); end
    checks++; if (rd_data_num !== num0) begin errors++; $display("FAIL b2b_num_held: got %0d want %0d", rd_data_num, num0); end
    m_axis_tready = 1'b1;
    model_drain();
    tick(2);
    checks++; if (m_axis_tvalid !== 1'b0 || rd_data_num !== exp_num || got_n - n0 != 1) begin
      errors++; $display("FAIL b2b_accept: tvalid=%b num=%0d words=%0d want 0 %0d 1", m_axis_tvalid, rd_data_num, got_n - n0, exp_num); end
    checks++; if (got_data[8'(n0)] !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_data: got %h want deadbeef", got_data[8'(n0)]); end
  endtask

  task automatic test_frame_err();
    int n0, e0;
    n0 = got_n; e0 = err_pulses;
    run_frame(MODE_RD, 1'b0, 1'b0, 0, 12, 32'd0, 32'hABC, 5, 0);
    checks++; if (err_pulses - e0 != 1) begin errors++; $display("FAIL ferr_pulse: got %0d cycles want 1", err_pulses - e0); end
    checks++; if (got_n != n0 || m_axis_tvalid !== 1'b0 || rx_busy !== 1'b0) begin
      errors++; $display("FAIL ferr_quiet: words=%0d tvalid=%b busy=%b want 0 0 0", got_n - n0, m_axis_tvalid, rx_busy); end
    run_frame(MODE_RD, 1'b0, 1'b0, 0, 12, 32'd0, 32'hABC, 12, 0);
    checks++; if (got_n - n0 != 1 || got_data[8'(n0)] !== 32'h0000_0ABC || err_pulses - e0 != 1) begin
      errors++; $display("FAIL ferr_recover: words=%0d data=%h want 1 00000abc", got_n - n0, got_data[8'(n0)]); end
  endtask

  task automatic test_mode_wr();
    int n0, e0, b0;
    logic [15:0] num0;
    n0 = got_n; e0 = err_pulses; b0 = busy_cycles; num0 = rd_data_num;
    run_frame(MODE_WR, 1'b0, 1'b0, 0, 8, 32'd0, 32'hFF, 8, 0);
    run_frame(MODE_WR, 1'b1, 1'b0, 8, 8, 32'hFF, 32'hFF, 12, 0);
    checks++; if (got_n != n0 || m_axis_tvalid !== 1'b0 || busy_cycles != b0 || err_pulses != e0 || rd_data_num !== num0) begin
      errors++; $display("FAIL wr_mode_idle: words=%0d tvalid=%b busy=%0d ferr=%0d num=%0d want 0 0 0 0 %0d",
                         got_n - n0, m_axis_tvalid, busy_cycles - b0, err_pulses - e0, rd_data_num, num0); end
    // frame aborted by a mode change part way through
    w_r_mode = MODE_RD; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; rd_width = 6'd8;
    tick(2);
    spi_start();
    for (int k = 0; k < 3; k++) spi_bit(1'b1);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", rx_busy); end
    w_r_mode = MODE_WR;
    tick(2);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after: got %b want 0", rx_busy); end
    for (int k = 0; k < 5; k++) spi_bit(1'b1);
    spi_end();
    w_r_mode = MODE_RD;
    tick(2);
    checks++; if (got_n != n0 || err_pulses != e0 || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL abort_quiet: words=%0d ferr=%0d tvalid=%b want 0 0 0", got_n - n0, err_pulses - e0, m_axis_tvalid); end
  endtask

  task automatic test_reset_mid();
    int n0;
    w_r_mode = MODE_RD; cpol = 1'b0; cpha = 1'b0; sck = 1'b0; rd_width = 6'd16;
    tick(2);
    spi_start();
    for (int k = 0; k < 10; k++) spi_bit(1'($urandom));
    cs = 1'b1; sck = cpol; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_reset();
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'd0 || rx_busy !== 1'b0 || overflow !== 1'b0 ||
                  frame_err !== 1'b0 || rd_data_num !== 16'd0) begin
      errors++; $display("FAIL midreset_outputs: tvalid=%b tdata=%h busy=%b ovf=%b ferr=%b num=%0d want all 0",
                         m_axis_tvalid, m_axis_tdata, rx_busy, overflow, frame_err, rd_data_num); end
    tick(2);
    n0 = got_n;
    run_frame(MODE_RD, 1'b0, 1'b0, 0, 16, 32'd0, 32'h8001, 16, 0);
    checks++; if (got_n - n0 != 1 || got_data[8'(n0)] !== 32'h0000_8001 || rd_data_num !== 16'd1) begin
      errors++; $display("FAIL midreset_next: words=%0d data=%h num=%0d want 1 00008001 1", got_n - n0, got_data[8'(n0)], rd_data_num); end
  endtask

  task automatic test_random();
    int n0, e0, wr, rd, skip, rb, full, edges, extra;
    logic [1:0] mode;
    logic [31:0] data, cmd;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      case ($urandom_range(0, 3))
        0:       mode = MODE_WR;
        1:       mode = MODE_CMD_RD;
        default: mode = MODE_RD;
      endcase
      wr = $urandom_range(0, 34); rd = $urandom_range(0, 34);
      data = $urandom; cmd = $urandom;
      skip = (mode == MODE_CMD_RD) ? ((wr > 32) ? 32 : wr) : 0;
      rb = (rd > 32) ? 32 : rd;
      full = skip + rb;
      edges = full; extra = $urandom_range(0, 2);
      if (full > 0 && $urandom_range(0, 3) == 0) begin edges = $urandom_range(0, full - 1); extra = 0; end
      n0 = got_n; e0 = err_pulses;
      run_frame(mode, 1'($urandom), 1'($urandom), wr, rd, cmd, data, edges, extra);
      checks++;
      if ((got_n - n0) != int'(exp_push) || (exp_push && got_data[8'(n0)] !== exp_word) || (err_pulses - e0) != int'(exp_err)) begin
        errors++; $display("FAIL random_frame%0d: words=%0d data=%h ferr=%0d want %0d %h %0d (mode=%b wr=%0d rd=%0d edges=%0d)",
                           i, got_n - n0, got_data[8'(n0)], err_pulses - e0, exp_push, exp_word, exp_err, mode, wr, rd, edges); end
    end
    checks++; if (rd_data_num !== exp_num || overflow !== exp_overflow) begin
      errors++; $display("FAIL random_totals: num=%0d ovf=%b want %0d %b", rd_data_num, overflow, exp_num, exp_overflow); end
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sck = 1'b0; cpol = 1'b0; cpha = 1'b0; miso = 1'b0;
    m_axis_tready = 1'b1; w_r_mode = MODE_RD; wr_width = 6'd0; rd_width = 6'd8;
    model_reset();
    test_reset();
    test_read_basic();
    test_cmd_read();
    test_back_to_back();
    test_frame_err();
    test_mode_wr();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_rx.md
Name: spi_rx

Overview:
- SPI master receive path: samples MISO using the cs/sck pair generated by the spi_cs_sck block and packs each frame into one 32-bit word.
- Delivers words to the PS/DMA side over an AXI4-Stream master port with a single-entry output holding register.
- Companion to the master transmit path. Shares the cpol/cpha/w_r_mode/wr_width/rd_width configuration.
- Active in read-only (00) and command-read (10) modes. In command-read mode it skips the command bits driven by the transmit path.

Parameters:
- system_clk, 50_000000, system clock frequency in Hz (documentation/consistency only).
- spi_rate, 5_000000, SPI bit rate in bps. Sets the minimum clk cycles between sck edges (at least 4).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- cs  input  1  chip select from spi_cs_sck, active low
- sck  input  1  raw sck from spi_cs_sck, synchronous to clk
- cpol  input  1  idle level of sck
- cpha  input  1  0: sample on leading edge; 1: sample on trailing edge
- w_r_mode  input  2  00 read-only, 01 write-only, 10 command-read, 11 reserved
- wr_width  input  6  command bits to skip in mode 10 (0..32)
- rd_width  input  6  read bits per frame (0..32)
- miso  input  1  slave data in
- m_axis_tdata  output  32  received word, right-justified, upper bits zero
- m_axis_tvalid  output  1  word valid
- m_axis_tready  input  1  downstream accept
- rx_busy  output  1  high while a frame is being received
- overflow  output  1  sticky: a completed frame was dropped because the output register was full
- frame_err  output  1  one-cycle pulse: cs rose before all expected bits were sampled
- rd_data_num  output  16  count of words accepted downstream, wraps at 65535->0

Behaviour:
- Reset (rst=1 at a clk edge) drives all outputs and registers to 0, with two exceptions: cs_reg resets to 1 and sck_reg resets to cpol. This includes reset in the middle of a frame; any partial word is discarded.
- Edge detection uses cs_reg/sck_reg, which are cs and sck registered once.
  - cs fall: cs_reg=1 and cs=0. cs rise: cs_reg=0 and cs=1.
  - Sample edge: a rising sck edge when cpol==cpha, otherwise a falling sck edge.
  - On the clk where a sample edge is detected, the current miso is taken.
- Expected counts per frame:
  - skip = wr_width in mode 10, 0 in mode 00.
  - rbits = rd_width.
  - Widths above 32 are treated as 32.
- State machine:
  - IDLE: wait for a cs fall. On cs fall: clear the bit counter and shift register, and set rx_busy=1. Go to SKIP if skip>0, else SHIFT.
  - SKIP: count sample edges and discard miso. When the count reaches skip: go to SHIFT and clear the counter.
  - SHIFT: on each sample edge, shift left by one and insert miso at bit0 (MSB first), and increment the counter. When the count reaches rbits, go to WAIT_CS. If rbits=0, go straight to WAIT_CS.
  - WAIT_CS: ignore further sck edges. On cs rise, complete the frame:
    - If m_axis_tvalid=0 or m_axis_tready=1, load tdata and set tvalid=1 on the next clk. tvalid is therefore visible 1 cycle after the cycle in which cs rise is detected.
    - Otherwise drop the word and set overflow=1.
    - If rbits=0, push nothing.
    - In all cases, return to IDLE and clear rx_busy.
  - cs rise in SKIP or SHIFT (truncated frame): pulse frame_err for 1 cycle, discard the word, go to IDLE, clear rx_busy.
- AXIS handshake:
  - tdata and tvalid stay stable until tvalid&&tready.
  - On acceptance: tvalid=0 and rd_data_num increments, unless a new word loads in the same cycle, in which case tvalid stays 1 with the new data.
- Mode 01/11:
  - The FSM is held in IDLE and rx_busy=0.
  - A change into 01/11 in the middle of a frame aborts the frame with no push and no frame_err.
  - A pending output word stays until accepted; rd_data_num holds its value.
- Simultaneous cs fall and sample edge in IDLE: the sck edge is ignored.
- overflow clears only on rst.

Decomposition:
- Shared package spi_pkg holds:
  - the mode constants MODE_RD=2'b00, MODE_WR=2'b01, MODE_CMD_RD=2'b10;
  - the rx state encodings;
  - the divider formula N=max(4, system_clk/spi_rate).
- One sub-module is natural: spi_edge_det, which registers cs/sck and outputs cs_fall, cs_rise and sample_edge given cpol/cpha. The transmit path can reuse it.

Test Plan:
- Mode 00, cpol=0 cpha=0, rd_width=8, slave returns 0xA5, tready=1 -> tdata=0x000000A5, tvalid high 1 cycle, rd_data_num=1.
- Mode 10, cpol=1 cpha=1, wr_width=8, rd_width=16, miso=0xFF during command then 0x1234 -> tdata=0x00001234 (command bits discarded).
- Mode 00, rd_width=32, cpha=1, two back-to-back frames 0xDEADBEEF then 0x01234567 with tready=0 -> first word held, second dropped, overflow=1, rd_data_num=0 until tready; after acceptance rd_data_num=1.
- Mode 00, rd_width=12, cs rises after 5 sample edges -> frame_err pulses 1 cycle, no tvalid, FSM in IDLE, next full frame 0xABC received correctly.
- rst asserted mid-SHIFT (bit 10 of 16) -> all outputs 0 next cycle; following 16-bit frame 0x8001 -> tdata=0x00008001.
- Mode 01 with sck/cs toggling and miso=1 -> tvalid, rx_busy, frame_err and rd_data_num all remain 0.
